// File: rtl/sigdiv_if.sv
// Operand/result handshake bundle for the significand divider.
// Latency: none, wiring only. Backpressure: carries valid/ready on both sides.
interface sigdiv_if #(parameter int NSIG = 10);
    logic            in_valid;
    logic            in_ready;
    logic [NSIG:0]   a;
    logic [NSIG:0]   b;
    logic            out_valid;
    logic            out_ready;
    logic [NSIG+1:0] q;
    logic            sticky;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, sticky
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, sticky
    );
endinterface

// File: rtl/sigdiv.sv
// Restoring significand divider: q = floor(a*2^(NSIG+1)/b), one quotient bit per clock.
// Latency: out_valid rises NSIG+2 edges after acceptance; one operation in flight at a time.
// Backpressure: result held in DONE until out_ready; in_ready low from acceptance to transfer.
module sigdiv #(
    parameter int NSIG = 10
) (
    input  logic     clk,
    input  logic     rst_n,
    sigdiv_if.slave  bus
);
    localparam int QW = NSIG + 2;
    localparam int CW = $clog2(NSIG + 2);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [QW-1:0] rem;
    logic [QW-1:0] div;
    logic [QW-1:0] qw;
    logic [QW-1:0] q_r;
    logic          sticky_r;
    logic [CW-1:0] cnt;

    logic          ge;
    logic          last;
    logic [QW-1:0] diff;
    logic [QW-1:0] rem_step;
    logic [QW-1:0] q_step;

    // rem < 2*div keeps diff below div, so the left shift never drops a set bit
    assign ge       = rem >= div;
    assign diff     = ge ? rem - div : rem;
    assign rem_step = diff << 1;
    assign q_step   = {qw[QW-2:0], ge};
    assign last     = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid)  state_nxt = RUN;
            RUN:     if (last)          state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            div      <= '0;
            qw       <= '0;
            cnt      <= '0;
            q_r      <= '0;
            sticky_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        rem <= {1'b0, bus.a};
                        div <= {1'b0, bus.b};
                        qw  <= '0;
                        cnt <= CW'(NSIG + 1);
                    end
                end
                RUN: begin
                    rem <= rem_step;
                    qw  <= q_step;
                    if (last) begin
                        // divide-by-zero reports a saturated, inexact quotient
                        q_r      <= (div == '0) ? '1 : q_step;
                        sticky_r <= (div == '0) || (diff != '0);
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.q         = q_r;
    assign bus.sticky    = sticky_r;
endmodule

// File: tb/tb_sigdiv.sv
// Directed-vector and randomized bench for sigdiv (NSIG=10).
module tb_sigdiv;
    localparam int NSIG = 10;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    sigdiv_if #(.NSIG(NSIG)) bus ();

    sigdiv #(.NSIG(NSIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [10:0] a;
        logic [10:0] b;
        logic [11:0] q;
        logic        s;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One operation: accept, wait for result, optionally stall, then transfer.
    task automatic do_op(input logic [10:0] ta, input logic [10:0] tb_, input int stall,
                         output logic [11:0] rq, output logic rs, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_op", int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.a         = ta;
        bus.b         = tb_;
        bus.out_ready = (stall == 0);
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        rq = bus.q;
        rs = bus.sticky;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check("stall_hold_valid", int'(bus.out_valid), 1);
            check("stall_hold_q", int'(bus.q), int'(rq));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_xfer_out_valid", int'(bus.out_valid), 0);
        check("post_xfer_in_ready", int'(bus.in_ready), 1);
    endtask

    initial begin
        logic [11:0] rq;
        logic        rs;
        int          lat;
        logic [10:0] ra, rb;
        logic [21:0] num;
        int          eq, er;

        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{11'd1024, 11'd1024, 12'd2048, 1'b0};
        vecs[1] = '{11'd2047, 11'd1024, 12'd4094, 1'b0};
        vecs[2] = '{11'd1024, 11'd1536, 12'd1365, 1'b1};
        vecs[3] = '{11'd1024, 11'd2047, 12'd1024, 1'b1};
        vecs[4] = '{11'd1536, 11'd0,    12'd4095, 1'b1};
        vecs[5] = '{11'd1536, 11'd1024, 12'd3072, 1'b0};
        vecs[6] = '{11'd1024, 11'd1025, 12'd2046, 1'b1};
        vecs[7] = '{11'd2047, 11'd2047, 12'd2048, 1'b0};
        vecs[8] = '{11'd1100, 11'd1100, 12'd2048, 1'b0};

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;
        rst_n         = 1'b0;
        #12;
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_q", int'(bus.q), 0);
        check("rst_sticky", int'(bus.sticky), 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_op(vecs[i].a, vecs[i].b, 0, rq, rs, lat);
            check($sformatf("vec%0d_latency", i), lat, 12);
            check($sformatf("vec%0d_q", i), int'(rq), int'(vecs[i].q));
            check($sformatf("vec%0d_sticky", i), int'(rs), int'(vecs[i].s));
        end

        // Backpressure: hold the result for 5 cycles, ignore a new operand pulse.
        @(negedge clk);
        bus.in_valid  = 1'b1;
        bus.a         = 11'd1024;
        bus.b         = 11'd1536;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("bp_latency", lat, 12);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.in_valid = 1'b1;
                bus.a        = 11'd2047;
                bus.b        = 11'd1024;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_q", int'(bus.q), 1365);
            check("bp_sticky", int'(bus.sticky), 1);
            check("bp_in_ready", int'(bus.in_ready), 0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_xfer_out_valid", int'(bus.out_valid), 0);
        check("bp_xfer_in_ready", int'(bus.in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        check("bp_no_ghost_op", int'(bus.out_valid), 0);
        check("bp_idle_in_ready", int'(bus.in_ready), 1);

        // Reset four cycles into a run.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a        = 11'd2047;
        bus.b        = 11'd1024;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_in_ready", int'(bus.in_ready), 1);
        check("midrst_q", int'(bus.q), 0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(11'd2047, 11'd1024, 0, rq, rs, lat);
        check("after_rst_latency", lat, 12);
        check("after_rst_q", int'(rq), 4094);
        check("after_rst_sticky", int'(rs), 0);

        // Random normalized operands with random result stalls.
        for (int n = 0; n < 1000; n++) begin
            ra  = 11'($urandom_range(1024, 2047));
            rb  = 11'($urandom_range(1024, 2047));
            num = {ra, 11'd0};
            eq  = int'(num / {11'd0, rb});
            er  = int'(num % {11'd0, rb});
            do_op(ra, rb, int'($urandom_range(0, 3)), rq, rs, lat);
            check("rnd_latency", lat, 12);
            check("rnd_q", int'(rq), eq);
            check("rnd_sticky", int'(rs), int'(er != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
